mod_n_down_timer: RTL and testbench
===================================

// Module: mod_n_down_timer
// PURPOSE
//  Loadable mod-N down-counter/timer. It is the counting-down counterpart of the
//  free-running mod-N up counter. A period L is accepted via a valid/ready load
//  handshake. The block counts L..0 on enabled cycles and flags terminal count.
//  It runs either one-shot or auto-reload (mod-(L+1)).
//  Used as a programmable tick/timeout generator beside the up counters in the datapath.
// PARAMETERS
//  WIDTH  8  counter width; load values 0..2**WIDTH-1, i.e. periods 1..2**WIDTH cycles
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  load_valid  in   1      load request; value/mode qualified by this
//  load_ready  out  1      block can accept a load this cycle
//  load_value  in   WIDTH  start value L (period = L+1 enabled cycles)
//  load_auto   in   1      1 = auto-reload on terminal count, 0 = one-shot
//  enable      in   1      count enable; count advances only when high
//  abort       in   1      cancel current run, return to IDLE
//  count       out  WIDTH  current count value (registered)
//  busy        out  1      high in RUN
//  done        out  1      high in DONE (one-shot completed)
//  tc_pulse    out  1      one-cycle terminal-count strobe (registered)
// BEHAVIOUR
//  - States: IDLE, RUN, DONE. Reset -> IDLE, count=0, tc_pulse=0. busy=0, done=0.
//    After reset, load_ready=1.
//  - Internal regs: reload_reg[WIDTH], auto_reg. Both reset to 0.
//  - load_ready = (state != RUN) && !abort. This is combinational and has no dependency on load_valid.
//  - Load accept (load_valid && load_ready at posedge), from IDLE or DONE:
//    count<=load_value, reload_reg<=load_value, auto_reg<=load_auto, state->RUN.
//    done clears the same edge.
//  - RUN, abort=1: state->IDLE, count<=0, tc_pulse stays 0. abort beats enable and terminal count.
//  - RUN, enable=0: all state held. tc_pulse=0.
//  - RUN, enable=1, count!=0: count<=count-1.
//  - RUN, enable=1, count==0: tc_pulse<=1 for exactly the next cycle.
//    If auto_reg=1, count<=reload_reg and the block stays in RUN.
//    If auto_reg=0, state->DONE and count stays 0.
//  - Latency: the first tc_pulse is high in the cycle after the (L+1)th enabled cycle of RUN.
//    The first enabled cycle of RUN is the cycle in which count==L is visible.
//  - Auto mode count sequence: L, L-1, ..., 0, L, ... with tc_pulse at each wrap.
//    There is no gap cycle at reload.
//  - L=0: terminal count on every enabled cycle.
//    In auto mode, tc_pulse stays high continuously while enable=1.
//  - L=2**WIDTH-1: there is no overflow. Arithmetic is pure WIDTH-bit decrement and never goes below 0.
//  - DONE: count=0, done=1, load_ready=1 unless abort. abort in DONE -> IDLE, done<=0.
//  - IDLE: count holds 0. enable is ignored. abort is a no-op.
//  - load_valid during RUN is ignored. No pending/queued load exists.
//  - rst_n low at any time, including mid-run: immediate return to reset values, independent of clk.
// TESTING
//  1. Reset: rst_n low, then release -> count=0, busy=0, done=0, tc_pulse=0, load_ready=1.
//  2. One-shot: load 3, auto=0, enable=1 -> count 3,2,1,0.
//     Then tc_pulse=1 for 1 cycle, done=1, count=0, load_ready=1.
//  3. Auto: load 2, auto=1, enable=1 for 9 cycles -> count 2,1,0,2,1,0,2,1,0.
//     tc_pulse on every 3rd cycle. busy stays 1 throughout.
//  4. Gating: load 4, enable pattern 1,0,0,1,1,0,1,1 -> count holds on every enable=0 cycle.
//     tc_pulse appears only after the 5th enabled cycle.
//  5. Abort/ignore: load 9, run to count 5, pulse load_valid (value 1), then abort ->
//     the load is ignored (count stays on its sequence), then IDLE, count=0, no tc_pulse, load_ready=1.
//  6. Edge cases:
//     - load 0, auto=1 -> tc_pulse high every enabled cycle.
//     - load 255, auto=0 -> tc_pulse after 256 enabled cycles.
//     - Assert rst_n mid-count -> all outputs cleared asynchronously.

Source files
------------

// File: rtl/mod_n_down_timer.sv
// Loadable mod-N down-counter/timer: counts L..0 on enabled cycles, flags terminal
// count, and either stops (one-shot) or reloads L with no gap cycle (auto-reload).
module mod_n_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_auto,
  input  logic             enable,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] reload_reg;
  logic             auto_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             tc_reg;

  // A load can only land when the timer is not running; abort vetoes it.
  assign load_ready = (state_reg != RUN) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      auto_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      tc_reg     <= 1'b0;
    end else begin
      tc_reg <= 1'b0;
      case (state_reg)
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            count_reg <= '0;
            busy_reg  <= 1'b0;
          end else if (enable) begin
            if (count_reg == '0) begin
              tc_reg <= 1'b1;
              if (auto_reg) begin
                count_reg <= reload_reg;
              end else begin
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end
            end else begin
              count_reg <= count_reg - ONE;
            end
          end
        end
        default: begin
          // IDLE and DONE behave alike apart from the done flag.
          if (load_valid && load_ready) begin
            state_reg  <= RUN;
            count_reg  <= load_value;
            reload_reg <= load_value;
            auto_reg   <= load_auto;
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
          end else if (abort) begin
            state_reg <= IDLE;
            count_reg <= '0;
            done_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign count    = count_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign tc_pulse = tc_reg;

endmodule

// File: tb/tb_mod_n_down_timer.sv
// Bench for mod_n_down_timer: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an elapsed-cycle arithmetic model.
module tb_mod_n_down_timer;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             load_auto;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_pulse;

  int errors = 0;
  int checks = 0;

  mod_n_down_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_auto  (load_auto),
    .enable     (enable),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .tc_pulse   (tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by its period L, mode, and the number n of enabled
  // cycles seen since the load; the count follows directly from n.
  bit m_run, m_done, m_auto, m_tc;
  int m_L, m_n;

  function automatic int exp_count();
    if (!m_run) return 0;
    if (m_auto) return m_L - (m_n % (m_L + 1));
    return m_L - m_n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_auto = 0; m_tc = 0; m_L = 0; m_n = 0;
    end else begin
      m_tc = 0;
      if (m_run) begin
        if (abort) begin
          m_run = 0;
        end else if (enable) begin
          if (m_n % (m_L + 1) == m_L) m_tc = 1;
          m_n++;
          if (!m_auto && m_n == m_L + 1) begin
            m_run  = 0;
            m_done = 1;
          end
        end
      end else if (abort) begin
        m_done = 0;
      end else if (load_valid) begin
        m_run  = 1;
        m_done = 0;
        m_L    = int'(load_value);
        m_auto = load_auto;
        m_n    = 0;
        $display("load L=%0d auto=%0d at %0t", m_L, m_auto, $time);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("count", 32'(count), 32'(exp_count()));
      check("busy", 32'(busy), 32'(m_run));
      check("done", 32'(done), 32'(m_done));
      check("tc_pulse", 32'(tc_pulse), 32'(m_tc));
      check("load_ready", 32'(load_ready), 32'(!m_run && !abort));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int value, input bit auto_mode);
    load_valid = 1'b1;
    load_value = WIDTH'(value);
    load_auto  = auto_mode;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic leave_run();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_value = '0; load_auto = 1'b0;
    enable = 1'b0; abort = 1'b0;
    #13 rst_n = 1'b1;
    #1;
    check("reset count", 32'(count), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset tc", 32'(tc_pulse), 32'd0);
    check("reset load_ready", 32'(load_ready), 32'd1);
    tick();

    // One-shot, L=3
    $display("scenario one-shot L=3");
    enable = 1'b1;
    do_load(3, 1'b0);
    check("os first count", 32'(count), 32'd3);
    check("os busy", 32'(busy), 32'd1);
    for (int i = 2; i >= 0; i--) begin
      tick();
      check("os count seq", 32'(count), 32'(i));
    end
    tick();
    check("os tc", 32'(tc_pulse), 32'd1);
    check("os done", 32'(done), 32'd1);
    check("os load_ready", 32'(load_ready), 32'd1);
    tick();
    check("os tc single", 32'(tc_pulse), 32'd0);

    // Auto, L=2, 9 enabled cycles
    $display("scenario auto L=2");
    do_load(2, 1'b1);
    for (int i = 1; i < 9; i++) begin
      tick();
      check("auto count seq", 32'(count), 32'(2 - (i % 3)));
      check("auto tc", 32'(tc_pulse), 32'((i % 3) == 0));
      check("auto busy", 32'(busy), 32'd1);
    end
    leave_run();

    // Enable gating, L=4
    $display("scenario gating L=4");
    do_load(4, 1'b0);
    begin
      logic [7:0] pat;
      pat = 8'b11011001;  // applied LSB first: 1,0,0,1,1,0,1,1
      for (int i = 0; i < 8; i++) begin
        enable = pat[i];
        tick();
        if (i < 7) check("gate no early tc", 32'(tc_pulse), 32'd0);
      end
    end
    check("gate tc", 32'(tc_pulse), 32'd1);
    check("gate done", 32'(done), 32'd1);

    // Load during RUN is ignored, then abort
    $display("scenario abort L=9");
    enable = 1'b1;
    do_load(9, 1'b0);
    repeat (4) tick();
    check("abort pre count", 32'(count), 32'd5);
    load_valid = 1'b1; load_value = 8'd1;
    tick();
    load_valid = 1'b0;
    check("ignored load", 32'(count), 32'd4);
    abort = 1'b1;
    #1 check("abort load_ready", 32'(load_ready), 32'd0);
    tick();
    abort = 1'b0;
    #1;
    check("abort count", 32'(count), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort tc", 32'(tc_pulse), 32'd0);
    check("abort load_ready after", 32'(load_ready), 32'd1);

    // L=0 auto: terminal count every enabled cycle
    $display("scenario auto L=0");
    do_load(0, 1'b1);
    repeat (3) begin
      tick();
      check("l0 tc", 32'(tc_pulse), 32'd1);
    end
    leave_run();

    // L=255 one-shot: 256 enabled cycles
    $display("scenario one-shot L=255");
    do_load(255, 1'b0);
    repeat (255) tick();
    check("l255 count", 32'(count), 32'd0);
    check("l255 no tc yet", 32'(tc_pulse), 32'd0);
    tick();
    check("l255 tc", 32'(tc_pulse), 32'd1);
    check("l255 done", 32'(done), 32'd1);

    // Asynchronous reset mid-run
    $display("scenario async reset");
    do_load(7, 1'b1);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst count", 32'(count), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst done", 32'(done), 32'd0);
    check("arst tc", 32'(tc_pulse), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Randomized traffic, checked by the per-cycle compare process
    $display("scenario random");
    for (int i = 0; i < 4000; i++) begin
      load_valid = ($urandom_range(0, 3) == 0);
      load_value = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      load_auto  = 1'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      abort      = ($urandom_range(0, 29) == 0);
      tick();
    end
    load_valid = 1'b0; abort = 1'b0; enable = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
